// File: rtl/cache_pkg.sv
// Shared types and width helpers for the direct-mapped cache.
// Contents: FSM state type and functions deriving word/index/tag field widths
// from the LINES/WORDS geometry (byte offset is always 2 bits).
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cache_state_t;

  function automatic int unsigned word_bits(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned index_bits(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned lines, input int unsigned words);
    return 32 - 2 - $clog2(words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/dm_cache_if.sv
// CPU-side load/store port of the cache.
// master: the CPU (drives address, store data, strobes, size; receives rdata/hold).
// slave : the cache.
interface dm_cache_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ce_n;
  logic        cpu_we_n;
  logic        cpu_bw;
  logic [31:0] cpu_rdata;
  logic        cpu_hold;

  modport master (
    output cpu_addr, cpu_wdata, cpu_ce_n, cpu_we_n, cpu_bw,
    input  cpu_rdata, cpu_hold
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_ce_n, cpu_we_n, cpu_bw,
    output cpu_rdata, cpu_hold
  );
endinterface

// File: rtl/cache_store.sv
// Valid/tag/data storage for the direct-mapped cache.
// Ports: combinational read (rd_*), synchronous word write (ww_*), synchronous
// byte-lane write (wb_*), valid-set with tag write (vs_*); valid bits clear
// asynchronously on reset_n low. Data and tag arrays are not reset.
module cache_store #(
  parameter int unsigned LINES = 8,
  parameter int unsigned WORDS = 4,
  parameter int unsigned TAG_W = 25,
  localparam int unsigned IW = $clog2(LINES),
  localparam int unsigned WW = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IW-1:0]    rd_index,
  input  logic [WW-1:0]    rd_word,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             ww_en,
  input  logic [IW-1:0]    ww_index,
  input  logic [WW-1:0]    ww_word,
  input  logic [31:0]      ww_data,
  input  logic             wb_en,
  input  logic [IW-1:0]    wb_index,
  input  logic [WW-1:0]    wb_word,
  input  logic [1:0]       wb_lane,
  input  logic [7:0]       wb_data,
  input  logic             vs_en,
  input  logic [IW-1:0]    vs_index,
  input  logic [TAG_W-1:0] vs_tag
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (vs_en) begin
      valid_q[vs_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (vs_en) tag_q[vs_index] <= vs_tag;
    if (ww_en) data_q[ww_index][ww_word] <= ww_data;
    if (wb_en) data_q[wb_index][wb_word][{wb_lane, 3'b000} +: 8] <= wb_data;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache.
// Ports: clk, reset_n (async, active low); cpu (dm_cache_if.slave) load/store
// port; mem_* external memory bus (mem_data tri-stated except during WRITE);
// mem_hold_i memory stall; hit_count/miss_count saturating statistics.
module dm_cache
  import cache_pkg::*;
#(
  parameter int unsigned LINES        = 8,
  parameter int unsigned WORDS        = 4,
  parameter logic [31:0] START_ADRESS = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  dm_cache_if.slave   cpu,
  output logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        mem_bw,
  input  logic        mem_hold_i,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned WW = word_bits(WORDS);
  localparam int unsigned IW = index_bits(LINES);
  localparam int unsigned TW = tag_bits(LINES, WORDS);
  localparam int unsigned LB = 2 + WW;  // bits below the index field

  logic [31:0]   off;
  logic [WW-1:0] word;
  logic [IW-1:0] index;
  logic [TW-1:0] tag;

  assign off   = cpu.cpu_addr - START_ADRESS;
  assign word  = off[2 +: WW];
  assign index = off[LB +: IW];
  assign tag   = off[31 -: TW];

  cache_state_t   state_q, state_d;
  logic [WW-1:0]  k_q, k_d;
  logic [31-LB:0] base_q, base_d;  // line number of the line being filled
  logic           done_q, done_d;  // store-completion cycle: request still on the bus
  logic [31:0]    hit_q, miss_q;

  logic          rd_valid, hit, hold, hit_ev, miss_ev;
  logic [TW-1:0] rd_tag;
  logic [31:0]   rd_data, rdata;
  logic          ww_en, wb_en, vs_en;
  logic [IW-1:0] ww_index;
  logic [WW-1:0] ww_word;
  logic [31:0]   ww_data;

  cache_store #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TAG_W (TW)
  ) u_store (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_index (index),
    .rd_word  (word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .ww_en    (ww_en),
    .ww_index (ww_index),
    .ww_word  (ww_word),
    .ww_data  (ww_data),
    .wb_en    (wb_en),
    .wb_index (index),
    .wb_word  (word),
    .wb_lane  (off[1:0]),
    .wb_data  (cpu.cpu_wdata[7:0]),
    .vs_en    (vs_en),
    .vs_index (base_q[IW-1:0]),
    .vs_tag   (base_q[31-LB -: TW])
  );

  assign hit = rd_valid && (rd_tag == tag);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    base_d   = base_q;
    done_d   = 1'b0;
    hold     = 1'b0;
    rdata    = '0;
    hit_ev   = 1'b0;
    miss_ev  = 1'b0;
    mem_addr = '0;
    mem_ce_n = 1'b1;
    mem_oe_n = 1'b1;
    mem_we_n = 1'b1;
    mem_bw   = 1'b0;
    ww_en    = 1'b0;
    ww_index = base_q[IW-1:0];
    ww_word  = k_q;
    ww_data  = mem_data;
    wb_en    = 1'b0;
    vs_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cpu.cpu_ce_n && !done_q) begin
          if (cpu.cpu_we_n) begin
            if (hit) begin
              rdata  = rd_data;
              hit_ev = 1'b1;
            end else begin
              hold    = 1'b1;
              miss_ev = 1'b1;
              base_d  = off[31:LB];
              k_d     = '0;
              state_d = FILL;
            end
          end else begin
            hold    = 1'b1;
            state_d = WRITE;
            // Store hit patches the cached copy now; the memory write follows.
            if (hit && cpu.cpu_bw) begin
              ww_en    = 1'b1;
              ww_index = index;
              ww_word  = word;
              ww_data  = cpu.cpu_wdata;
            end else if (hit) begin
              wb_en = 1'b1;
            end
          end
        end
      end
      FILL: begin
        hold     = 1'b1;
        mem_ce_n = 1'b0;
        mem_oe_n = 1'b0;
        mem_addr = {base_q, k_q, 2'b00} + START_ADRESS;
        if (!mem_hold_i) begin
          ww_en = 1'b1;
          if (k_q == WW'(WORDS - 1)) begin
            vs_en   = 1'b1;
            k_d     = '0;
            state_d = IDLE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      WRITE: begin
        hold     = 1'b1;
        mem_ce_n = 1'b0;
        mem_we_n = 1'b0;
        mem_bw   = cpu.cpu_bw;
        mem_addr = cpu.cpu_addr;
        if (!mem_hold_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_data      = (state_q == WRITE) ? cpu.cpu_wdata : 'z;
  assign cpu.cpu_hold  = hold & reset_n;
  assign cpu.cpu_rdata = rdata;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      done_q  <= done_d;
      if (hit_ev && hit_q != '1) hit_q <= hit_q + 32'd1;
      if (miss_ev && miss_q != '1) miss_q <= miss_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_dm_cache.sv
module tb_dm_cache;
  localparam int unsigned LINES     = 8;
  localparam int unsigned WORDS     = 4;
  localparam logic [31:0] START     = 32'h1001_0000;
  localparam int unsigned RAM_WORDS = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dm_cache_if cpu_bus ();
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;
  logic        mem_ce_n, mem_oe_n, mem_we_n, mem_bw, mem_hold;
  logic [31:0] hit_count, miss_count;

  dm_cache #(.LINES(LINES), .WORDS(WORDS), .START_ADRESS(START)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu        (cpu_bus),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ce_n   (mem_ce_n),
    .mem_oe_n   (mem_oe_n),
    .mem_we_n   (mem_we_n),
    .mem_bw     (mem_bw),
    .mem_hold_i (mem_hold),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned ram_idx(input logic [31:0] a);
    return ((a - START) >> 2) % RAM_WORDS;
  endfunction

  // External memory: stalls hold_cfg edges on a chosen fill word (or on a write).
  logic [31:0] ram [RAM_WORDS];
  int unsigned hold_cfg = 0, hold_word = 0, hold_left = 0;
  int          arm_tok = 0, arm_seen = 0;

  assign mem_hold = !mem_ce_n && (hold_left != 0) &&
                    (!mem_we_n || (((mem_addr - START) >> 2) % WORDS) == hold_word);
  assign mem_data = (!mem_ce_n && !mem_oe_n && mem_we_n) ? ram[ram_idx(mem_addr)] : 'z;

  always @(posedge clk) begin
    if (arm_tok != arm_seen) begin
      hold_left <= hold_cfg;
      arm_seen  <= arm_tok;
    end else if (mem_hold) begin
      hold_left <= hold_left - 1;
    end
    if (!mem_ce_n && !mem_we_n && !mem_hold) begin
      if (mem_bw) ram[ram_idx(mem_addr)] <= mem_data;
      else        ram[ram_idx(mem_addr)][{mem_addr[1:0], 3'b000} +: 8] <= mem_data[7:0];
    end
  end

  // Reference model: flat memory plus which line number each index holds.
  logic [31:0] ref_mem [RAM_WORDS];
  bit          ref_valid [LINES];
  int unsigned ref_tag [LINES];
  int unsigned ref_hits = 0, ref_misses = 0;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    int unsigned lat;
    logic [31:0] addr;
  } exp_t;
  exp_t exp_q[$];
  int   overlaps = 0;

  // Monitor: counts stall cycles, compares on each completion.
  initial begin : monitor
    int unsigned stall;
    exp_t        e;
    stall = 0;
    forever begin
      @(negedge clk);
      if (!mem_oe_n && !mem_we_n) overlaps++;
      if (!reset_n) begin
        stall = 0;
      end else if (!cpu_bus.cpu_ce_n) begin
        if (cpu_bus.cpu_hold) begin
          stall++;
        end else begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk(e.is_load ? "load_latency" : "store_latency", stall, e.lat);
            if (e.is_load) chk("load_rdata", cpu_bus.cpu_rdata, e.data);
            else           chk("ram_after_store", ram[ram_idx(e.addr)], e.data);
          end
          stall = 0;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input bit is_store, input bit bw,
                       input logic [31:0] wdata, input int unsigned hcyc,
                       input int unsigned hword);
    int unsigned w, line_no, idx, tg;
    exp_t        e;
    w       = ram_idx(addr);
    line_no = (addr - START) / (WORDS * 4);
    idx     = line_no % LINES;
    tg      = line_no / LINES;
    e.addr  = addr;
    if (is_store) begin
      if (bw) ref_mem[w] = wdata;
      else    ref_mem[w][{addr[1:0], 3'b000} +: 8] = wdata[7:0];
      e.is_load = 1'b0;
      e.data    = ref_mem[w];
      e.lat     = 2 + hcyc;
    end else begin
      if (ref_valid[idx] && ref_tag[idx] == tg) begin
        e.lat = 0;
      end else begin
        e.lat = WORDS + 1 + hcyc;
        ref_misses++;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
      end
      ref_hits++;
      e.is_load = 1'b1;
      e.data    = ref_mem[w];
    end
    exp_q.push_back(e);
    hold_cfg  = hcyc;
    hold_word = hword;
    arm_tok++;
    cpu_bus.cpu_addr  = addr;
    cpu_bus.cpu_wdata = wdata;
    cpu_bus.cpu_we_n  = !is_store;
    cpu_bus.cpu_bw    = bw;
    cpu_bus.cpu_ce_n  = 1'b0;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (!cpu_bus.cpu_hold) break;
      if (c > 200) begin
        $display("FAIL request_timeout: addr %h still stalled after %0d cycles", addr, c);
        $fatal(1, "request timeout");
      end
    end
    @(posedge clk);
    #1;
    cpu_bus.cpu_ce_n = 1'b1;
  endtask

  task automatic reset_checks();
    chk("rst_cpu_hold", cpu_bus.cpu_hold, 0);
    chk("rst_cpu_rdata", cpu_bus.cpu_rdata, 0);
    chk("rst_mem_ce_n", mem_ce_n, 1);
    chk("rst_mem_oe_n", mem_oe_n, 1);
    chk("rst_mem_we_n", mem_we_n, 1);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_bw", mem_bw, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
  endtask

  task automatic preload(input int unsigned i, input logic [31:0] v);
    ram[i]     <= v;
    ref_mem[i]  = v;
  endtask

  initial begin : driver
    logic [31:0] a, m0, x;
    cpu_bus.cpu_addr  = START;
    cpu_bus.cpu_wdata = '0;
    cpu_bus.cpu_ce_n  = 1'b1;
    cpu_bus.cpu_we_n  = 1'b1;
    cpu_bus.cpu_bw    = 1'b1;
    for (int i = 0; i < RAM_WORDS; i++) preload(i, $urandom);
    preload(0, 32'h11);
    preload(1, 32'h22);
    preload(2, 32'h33);
    preload(3, 32'h44);
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_checks();
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Cold read, then a hit on the last word of the same line.
    issue(START, 0, 1, 0, 0, 0);
    chk("cold_miss_count", miss_count, 32'd1);
    chk("cold_hit_count", hit_count, 32'd1);
    issue(START + 32'hC, 0, 1, 0, 0, 0);

    // Fill stretched by 3 hold cycles on word 2, then read the whole line back.
    issue(START + 32'h10, 0, 1, 0, 3, 2);
    for (int i = 0; i < WORDS; i++) issue(START + 32'h10 + 4 * i, 0, 1, 0, 0, 0);

    // Byte store hit, then word store miss.
    issue(START + 32'h1, 1, 0, 32'h0000_00AB, 1, 0);
    chk("byte_store_mem_word0", ram[0], 32'h0000_AB11);
    issue(START, 0, 1, 0, 0, 0);
    issue(START + 32'h104, 1, 1, 32'hDEAD_BEEF, 0, 0);
    issue(START + 32'h104, 0, 1, 0, 0, 0);

    // Conflict: two addresses mapping to the same index.
    m0 = miss_count;
    issue(START, 0, 1, 0, 0, 0);
    issue(START + LINES * WORDS * 4, 0, 1, 0, 0, 0);
    issue(START, 0, 1, 0, 0, 0);
    chk("conflict_misses", miss_count - m0, 32'd3);
    chk("hit_count_model", hit_count, ref_hits);
    chk("miss_count_model", miss_count, ref_misses);

    // Reset during fill of word 2.
    x = START + 32'h20;
    hold_cfg = 0;
    arm_tok++;
    cpu_bus.cpu_addr = x;
    cpu_bus.cpu_we_n = 1'b1;
    cpu_bus.cpu_ce_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("fill_word2_addr", mem_addr, x + 32'd8);
    chk("fill_word2_oe_n", mem_oe_n, 0);
    reset_n = 1'b0;
    #1;
    reset_checks();
    cpu_bus.cpu_ce_n = 1'b1;
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    issue(x, 0, 1, 0, 0, 0);
    chk("post_reset_miss_count", miss_count, 32'd1);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      int unsigned hc;
      bit          st, bw;
      a  = START + ($urandom_range(0, 127) << 2);
      st = ($urandom_range(0, 9) < 3);
      bw = st ? $urandom_range(0, 1) : 1'b1;
      if (st && !bw) a = a + $urandom_range(0, 3);
      hc = $urandom_range(0, 1) ? 0 : $urandom_range(1, 3);
      issue(a, st, bw, $urandom, hc, $urandom_range(0, WORDS - 1));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end

    repeat (2) @(posedge clk);
    chk("final_hit_count", hit_count, ref_hits);
    chk("final_miss_count", miss_count, ref_misses);
    chk("oe_we_overlap", overlaps, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
